spi_master_cfg: RTL and testbench

//   Parametrised full-duplex SPI master: DATA_W-bit frames, all four SPI modes (CPOL/CPHA),

---
 rtl/spi_master_cfg_pkg.sv | 16 +
 rtl/spi_master_cfg_clk_div.sv | 21 ++
 rtl/spi_master_cfg.sv | 117 +++++++++++
 tb/tb_spi_master_cfg.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/spi_master_cfg_pkg.sv
// spi_master_cfg_pkg: FSM state encoding and SPI mode constants shared by the SPI master and its bench.
package spi_master_cfg_pkg;
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEAD  = 3'd1,
        ST_XFER  = 3'd2,
        ST_TRAIL = 3'd3,
        ST_DONE  = 3'd4
    } state_t;
    localparam int CPOL_BIT = 1;
    localparam int CPHA_BIT = 0;
    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;
endpackage

// File: rtl/spi_master_cfg_clk_div.sv
// spi_master_cfg_clk_div: one-cycle tick every div+1 clk cycles while en is high.
module spi_master_cfg_clk_div #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);
    logic [DIV_W-1:0] cnt;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= (en && cnt != div) ? cnt + 1'b1 : '0;
            tick <= en && cnt == div;
        end
    end
endmodule

// File: rtl/spi_master_cfg.sv
// spi_master_cfg: full-duplex SPI master, all four modes, programmable SCLK divider, one-hot active-low chip selects.
// Define SPI_MASTER_LSB_FIRST_EN to add the lsb_first input (bit order chosen per frame).
module spi_master_cfg
    import spi_master_cfg_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NUM_CS = 4,
    parameter int DIV_W = 8,
    localparam int CS_IDX_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [DATA_W-1:0]   tx_data,
    input  logic [CS_IDX_W-1:0] cs_sel,
    input  logic [1:0]          mode,
    input  logic [DIV_W-1:0]    clk_div,
`ifdef SPI_MASTER_LSB_FIRST_EN
    input  logic                lsb_first,
`endif
    output logic                busy,
    output logic                done,
    output logic [DATA_W-1:0]   rx_data,
    output logic                sclk,
    output logic                mosi,
    input  logic                miso,
    output logic [NUM_CS-1:0]   cs_n
);
    localparam int EW = $clog2(2 * DATA_W);
    state_t state, state_nx;
    logic [DATA_W-1:0] tx_sr, rx_sr, src;
    logic [DIV_W-1:0] div_r;
    logic [EW-1:0] ecnt;
    logic [NUM_CS-1:0] cs_dec;
    logic cpha_r, lsb_r, lsb_in, lsb_cur, tick, en, accept, edge_ev, last_edge, sample, shift_ev;
`ifdef SPI_MASTER_LSB_FIRST_EN
    assign lsb_in = lsb_first;
`else
    assign lsb_in = 1'b0;
`endif
    assign en        = state == ST_LEAD || state == ST_XFER || state == ST_TRAIL;
    assign accept    = state == ST_IDLE && start;
    assign edge_ev   = state == ST_XFER && tick;
    assign last_edge = ecnt == EW'(2 * DATA_W - 1);
    // Even edge count is a leading edge: CPHA=0 samples there, CPHA=1 shifts there.
    assign sample    = edge_ev && ecnt[0] == cpha_r;
    assign shift_ev  = accept ? !mode[CPHA_BIT] : edge_ev && ecnt[0] != cpha_r;
    assign lsb_cur   = accept ? lsb_in : lsb_r;
    assign src       = accept ? tx_data : tx_sr;
    spi_master_cfg_clk_div #(.DIV_W(DIV_W)) u_div (
        .clk  (clk),
        .reset(reset),
        .en   (en),
        .div  (div_r),
        .tick (tick)
    );
    always_comb begin
        cs_dec = '1;
        for (int i = 0; i < NUM_CS; i++) cs_dec[i] = cs_sel != CS_IDX_W'(i);
    end
    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:  state_nx = start ? ST_LEAD : ST_IDLE;
            ST_LEAD:  state_nx = tick ? ST_XFER : ST_LEAD;
            ST_XFER:  state_nx = (tick && last_edge) ? ST_TRAIL : ST_XFER;
            ST_TRAIL: state_nx = tick ? ST_DONE : ST_TRAIL;
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            rx_data <= '0;
            sclk    <= 1'b0;
            mosi    <= 1'b0;
            cs_n    <= '1;
            tx_sr   <= '0;
            rx_sr   <= '0;
            div_r   <= '0;
            cpha_r  <= 1'b0;
            lsb_r   <= 1'b0;
            ecnt    <= '0;
        end else begin
            state <= state_nx;
            busy  <= state_nx != ST_IDLE;
            done  <= state == ST_TRAIL && tick;
            if (accept) begin
                div_r  <= clk_div;
                cpha_r <= mode[CPHA_BIT];
                lsb_r  <= lsb_in;
                cs_n   <= cs_dec;
                ecnt   <= '0;
            end
            if (shift_ev) begin
                mosi  <= lsb_cur ? src[0] : src[DATA_W-1];
                tx_sr <= lsb_cur ? src >> 1 : src << 1;
            end else if (accept) begin
                tx_sr <= tx_data;
            end
            if (sample) rx_sr <= lsb_r ? {miso, rx_sr[DATA_W-1:1]} : {rx_sr[DATA_W-2:0], miso};
            if (edge_ev) begin
                sclk <= ~sclk;
                ecnt <= ecnt + 1'b1;
            end else if (state == ST_IDLE) begin
                sclk <= mode[CPOL_BIT];
            end
            if (state == ST_TRAIL && tick) begin
                cs_n    <= '1;
                rx_data <= rx_sr;
            end
        end
    end
endmodule

// File: tb/tb_spi_master_cfg.sv
// tb_spi_master_cfg: table, random and corner-case checks of spi_master_cfg against a behavioural SPI slave.
module tb_spi_master_cfg;
    import spi_master_cfg_pkg::*;
    logic clk = 1'b0, reset = 1'b0, start = 1'b0, lsb_first = 1'b0;
    logic busy, done, sclk, mosi, miso;
    logic [7:0] tx_data = '0, clk_div = '0, rx_data;
    logic [1:0] cs_sel = '0, mode = '0;
    logic [3:0] cs_n;
    int n_vec = 0, n_err = 0;
    // Slave: drives bit (edge count)/2 of s_tx, captures mosi on its sample edges.
    int edges = 0, sidx;
    logic [7:0] s_tx = '0, s_rx = '0;
    logic s_cpha = 1'b0, loop = 1'b0;
    assign sidx = s_cpha ? (edges > 0 ? (edges - 1) / 2 : 0) : edges / 2;
    assign miso = loop ? mosi : (sidx < 8 ? s_tx[7-sidx] : 1'b0);
    always @(sclk) begin
        edges++;
        if ((edges % 2 == 1) != s_cpha) s_rx = {s_rx[6:0], mosi};
    end
    always #5 clk = ~clk;
    spi_master_cfg #(.DATA_W(8), .NUM_CS(4), .DIV_W(8)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .tx_data(tx_data),
        .cs_sel (cs_sel),
        .mode   (mode),
        .clk_div(clk_div),
`ifdef SPI_MASTER_LSB_FIRST_EN
        .lsb_first(lsb_first),
`endif
        .busy   (busy),
        .done   (done),
        .rx_data(rx_data),
        .sclk   (sclk),
        .mosi   (mosi),
        .miso   (miso),
        .cs_n   (cs_n)
    );
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic run_frame(input logic [1:0] m, input logic [7:0] dv, input logic [1:0] cs,
                             input logic [7:0] tx, input logic [7:0] sd, input logic lp,
                             input logic lf, input logic [7:0] exp_rx, input int exp_lat);
        int lat;
        @(negedge clk);
        mode = m; clk_div = dv; cs_sel = cs; tx_data = tx; lsb_first = lf;
        loop = lp; s_tx = sd; s_cpha = m[0];
        @(negedge clk);
        edges = 0; s_rx = '0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_accept", busy, 1);
        chk("cs_n_active", cs_n, 4'hF & ~(4'h1 << cs));
        chk("sclk_lead", sclk, m[1]);
        if (!m[0]) chk("mosi_first_bit", mosi, lf ? tx[0] : tx[7]);
        tx_data = 8'($urandom); mode = 2'($urandom); clk_div = 8'($urandom);
        cs_sel = 2'($urandom); lsb_first = 1'($urandom);
        lat = 0;
        while (done !== 1'b1 && lat < 6000) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, exp_lat);
        chk("rx_data", rx_data, exp_rx);
        chk("cs_n_release", cs_n, 4'hF);
        chk("sclk_idle_cpol", sclk, m[1]);
        if (!lp) chk("slave_rx", s_rx, tx);
        @(posedge clk); #1;
        chk("done_pulse", done, 0);
        chk("busy_clear", busy, 0);
        chk("rx_hold", rx_data, exp_rx);
    endtask
    typedef struct {
        logic [1:0] m;
        logic [7:0] dv;
        logic [1:0] cs;
        logic [7:0] tx;
        logic [7:0] sd;
        logic       lp;
        logic [7:0] rx;
        int         lat;
    } vec_t;
    vec_t tbl[7];
    initial begin
        int lat, ndone, dv;
        logic [7:0] sd;
        tbl[0] = '{SPI_MODE0, 8'd0,   2'd0, 8'hA5, 8'h00, 1'b1, 8'hA5, 19};
        tbl[1] = '{SPI_MODE1, 8'd0,   2'd1, 8'h3C, 8'hC3, 1'b0, 8'hC3, 19};
        tbl[2] = '{SPI_MODE2, 8'd0,   2'd3, 8'h3C, 8'hC3, 1'b0, 8'hC3, 19};
        tbl[3] = '{SPI_MODE3, 8'd0,   2'd0, 8'h3C, 8'hC3, 1'b0, 8'hC3, 19};
        tbl[4] = '{SPI_MODE0, 8'd3,   2'd2, 8'h5A, 8'h96, 1'b0, 8'h96, 73};
        tbl[5] = '{SPI_MODE3, 8'd1,   2'd3, 8'h81, 8'h7E, 1'b0, 8'h7E, 37};
        tbl[6] = '{SPI_MODE2, 8'hFF,  2'd1, 8'h0F, 8'hF0, 1'b0, 8'hF0, 4609};
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rx", rx_data, 0);
        chk("rst_sclk", sclk, 0);
        chk("rst_mosi", mosi, 0);
        chk("rst_cs_n", cs_n, 4'hF);
        @(negedge clk) reset = 1'b1;
        // Reset asserted in the middle of the data phase.
        @(negedge clk);
        mode = SPI_MODE0; clk_div = 0; cs_sel = 0; tx_data = 8'hFF; loop = 1'b1;
        @(negedge clk) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        chk("mid_cs_n", cs_n, 4'hE);
        chk("mid_sclk", sclk, 1);
        reset = 1'b0;
        #1;
        chk("arst_cs_n", cs_n, 4'hF);
        chk("arst_sclk", sclk, 0);
        chk("arst_busy", busy, 0);
        chk("arst_rx", rx_data, 0);
        @(negedge clk) reset = 1'b1;
        ndone = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("arst_no_done", ndone, 0);
        chk("arst_rx_kept", rx_data, 0);
        for (int i = 0; i < 7; i++)
            run_frame(tbl[i].m, tbl[i].dv, tbl[i].cs, tbl[i].tx, tbl[i].sd, tbl[i].lp, 1'b0, tbl[i].rx, tbl[i].lat);
        for (int i = 0; i < 12; i++) begin
            dv = $urandom_range(0, 3);
            sd = 8'($urandom);
            run_frame(2'($urandom), 8'(dv), 2'($urandom), 8'($urandom), sd, 1'b0, 1'b0, sd, 18 * (dv + 1) + 1);
        end
        // start held high: one frame, a one-cycle idle gap, then a second frame.
        @(negedge clk);
        mode = SPI_MODE0; clk_div = 0; cs_sel = 1; tx_data = 8'h66; loop = 1'b1;
        @(negedge clk) start = 1'b1;
        @(posedge clk); #1;
        ndone = 0;
        repeat (19) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("hold_done_count", ndone, 1);
        chk("hold_done_at_19", done, 1);
        chk("hold_rx", rx_data, 8'h66);
        @(posedge clk); #1;
        chk("hold_idle_gap", busy, 0);
        @(posedge clk); #1;
        chk("hold_restart", busy, 1);
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("hold_second_latency", lat, 19);
`ifdef SPI_MASTER_LSB_FIRST_EN
        run_frame(SPI_MODE0, 8'd0, 2'd0, 8'h01, 8'h00, 1'b1, 1'b1, 8'h01, 19);
        run_frame(SPI_MODE1, 8'd1, 2'd2, 8'h6A, 8'h00, 1'b1, 1'b1, 8'h6A, 37);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
